// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared receive-state type and checksum helper for uart_pkt_comm
package uart_pkt_pkg;

   typedef enum logic [1:0] {IDLE, DATA, CHK} rx_state_t;

   // Byte that brings cmd plus every data byte to a zero sum mod 256.
   function automatic logic [7:0] chk_sum(input logic [7:0] cmd, input logic [31:0] data);
      logic [7:0] sum;
      sum = cmd + data[31:24] + data[23:16] + data[15:8] + data[7:0];
      return 8'h00 - sum;
   endfunction

endpackage

// File: rtl/uart_pkt_comm_uart.sv
// rtl/uart_pkt_comm_uart.sv - 8N1 UART transceiver, BAUD_DIV clocks per bit
module uart_pkt_comm_uart #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       tx,
   output logic       rx_rdy,
   output logic [7:0] rx_data,
   input  logic       clr_rx_rdy,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done
);
   localparam int BW = $clog2(BAUD_DIV + 1);
   localparam logic [BW-1:0] BAUD_FULL = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

   logic          rx_s1, rx_s2, rx_busy;
   logic [BW-1:0] rx_baud;
   logic [3:0]    rx_bits;
   logic [8:0]    rx_shift;
   logic [9:0]    tx_shift;
   logic [BW-1:0] tx_baud;
   logic [3:0]    tx_bits;
   logic          tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   // Half-bit delay after the start edge, then sample mid-bit; the stop bit is the 10th sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_busy  <= 1'b0;
         rx_baud  <= '0;
         rx_bits  <= '0;
         rx_shift <= '0;
         rx_rdy   <= 1'b0;
      end else begin
         if (!rx_busy) begin
            if (!rx_s2) begin
               rx_busy <= 1'b1;
               rx_baud <= BAUD_HALF;
               rx_bits <= '0;
            end
         end else if (rx_baud == '0) begin
            rx_shift <= {rx_s2, rx_shift[8:1]};
            rx_baud  <= BAUD_FULL;
            rx_bits  <= rx_bits + 4'd1;
            if (rx_bits == 4'd9)
               rx_busy <= 1'b0;
         end else begin
            rx_baud <= rx_baud - BW'(1);
         end
         if (rx_busy && rx_baud == '0 && rx_bits == 4'd9)
            rx_rdy <= 1'b1;
         else if (clr_rx_rdy)
            rx_rdy <= 1'b0;
      end
   end

   assign rx_data = rx_shift[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_shift <= '1;
         tx_baud  <= '0;
         tx_bits  <= '0;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (!tx_busy) begin
            if (trmt) begin
               tx_shift <= {1'b1, tx_data, 1'b0};
               tx_baud  <= BAUD_FULL;
               tx_bits  <= '0;
               tx_busy  <= 1'b1;
            end
         end else if (tx_baud == '0) begin
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_baud  <= BAUD_FULL;
            tx_bits  <= tx_bits + 4'd1;
            if (tx_bits == 4'd9) begin
               tx_busy <= 1'b0;
               tx_done <= 1'b1;
            end
         end else begin
            tx_baud <= tx_baud - BW'(1);
         end
      end
   end

   assign tx = tx_shift[0];

endmodule

// File: rtl/uart_pkt_comm.sv
// rtl/uart_pkt_comm.sv - UART packet receiver with timeout/checksum and single-byte responder
module uart_pkt_comm
   import uart_pkt_pkg::*;
#(
   parameter int DATA_BYTES  = 2,
   parameter int BAUD_DIV    = 2604,
   parameter int CHK_EN      = 0,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    RX,
   output logic                    TX,
   input  logic [7:0]              resp,
   input  logic                    send_resp,
   output logic                    resp_sent,
   output logic                    tx_busy,
   output logic                    cmd_rdy,
   output logic [7:0]              cmd,
   output logic [8*DATA_BYTES-1:0] data,
   input  logic                    clr_cmd_rdy,
   output logic                    chk_err,
   output logic                    timeout_err
);
   localparam int DW = 8 * DATA_BYTES;
   localparam int CW = $clog2(DATA_BYTES + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST_BYTE = CW'(DATA_BYTES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

   rx_state_t     state, next_state;
   logic          rx_rdy, clr_rx_rdy, trmt, tx_done;
   logic [7:0]    rx_data;
   logic [7:0]    cmd_sh;
   logic [DW-1:0] data_sh, data_cat;
   logic [CW-1:0] byte_cnt;
   logic [TW-1:0] to_cnt;
   logic          to_hit, load_cmd, shift_data, commit, chk_fail;

   uart_pkt_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (RX),
      .tx         (TX),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .clr_rx_rdy (clr_rx_rdy),
      .trmt       (trmt),
      .tx_data    (resp),
      .tx_done    (tx_done)
   );

   // Shadow data with the arriving byte appended, so the final data byte can commit directly.
   if (DATA_BYTES > 1) begin : g_shift
      assign data_cat = {data_sh[DW-9:0], rx_data};
   end else begin : g_single
      assign data_cat = rx_data;
   end

   assign clr_rx_rdy = rx_rdy;
   assign to_hit     = (state != IDLE) && !rx_rdy && (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (rx_rdy)
               next_state = DATA;
         end
         DATA: begin
            if (rx_rdy && byte_cnt == LAST_BYTE)
               next_state = (CHK_EN != 0) ? CHK : IDLE;
            else if (to_hit)
               next_state = IDLE;
         end
         CHK: begin
            if (rx_rdy || to_hit)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      load_cmd   = 1'b0;
      shift_data = 1'b0;
      commit     = 1'b0;
      chk_fail   = 1'b0;
      case (state)
         IDLE: load_cmd = rx_rdy;
         DATA: begin
            shift_data = rx_rdy;
            commit     = rx_rdy && (byte_cnt == LAST_BYTE) && (CHK_EN == 0);
         end
         CHK: begin
            if (rx_rdy) begin
               if (rx_data == chk_sum(cmd_sh, 32'(data_sh)))
                  commit = 1'b1;
               else
                  chk_fail = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_sh      <= '0;
         data_sh     <= '0;
         byte_cnt    <= '0;
         to_cnt      <= '0;
         cmd         <= '0;
         data        <= '0;
         cmd_rdy     <= 1'b0;
         chk_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         chk_err     <= chk_fail;
         timeout_err <= to_hit;
         if (state == IDLE || rx_rdy)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + TW'(1);
         if (to_hit) begin
            cmd_sh   <= '0;
            data_sh  <= '0;
            byte_cnt <= '0;
         end else if (load_cmd) begin
            cmd_sh   <= rx_data;
            data_sh  <= '0;
            byte_cnt <= '0;
         end else if (shift_data) begin
            data_sh  <= data_cat;
            byte_cnt <= byte_cnt + CW'(1);
         end
         if (commit) begin
            cmd  <= cmd_sh;
            data <= (state == DATA) ? data_cat : data_sh;
         end
         // A commit outranks a same-cycle clear request.
         if (commit)
            cmd_rdy <= 1'b1;
         else if (clr_cmd_rdy || load_cmd)
            cmd_rdy <= 1'b0;
      end
   end

   assign trmt = send_resp && !tx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         resp_sent <= tx_done;
         if (trmt)
            tx_busy <= 1'b1;
         else if (tx_done)
            tx_busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_pkt_comm.sv
// tb/tb_uart_pkt_comm.sv - self-checking bench for uart_pkt_comm (2-byte plain and 3-byte checksummed)
module tb_uart_pkt_comm;
   localparam int BAUD   = 16;
   localparam int TO_CYC = 400;

   logic clk = 1'b0, rst_n = 1'b0;
   logic rx_a = 1'b1, rx_b = 1'b1;
   logic tx_a, tx_b;
   logic [7:0] resp_a = 8'h00, resp_b = 8'h00;
   logic send_a = 1'b0, send_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
   logic sent_a, sent_b, busy_a, busy_b, rdy_a, rdy_b;
   logic chk_a, chk_b, to_a, to_b;
   logic [7:0] cmd_a, cmd_b;
   logic [15:0] data_a;
   logic [23:0] data_b;

   int checks = 0, errors = 0;
   int sent_cnt_a = 0, sent_cnt_b = 0, chk_cnt_b = 0, to_cnt_a = 0, to_cnt_b = 0;
   logic [7:0] tx_q[$];

   uart_pkt_comm #(.DATA_BYTES(2), .BAUD_DIV(BAUD), .CHK_EN(0), .TIMEOUT_CYC(TO_CYC)) u_a (
      .clk(clk), .rst_n(rst_n), .RX(rx_a), .TX(tx_a), .resp(resp_a), .send_resp(send_a),
      .resp_sent(sent_a), .tx_busy(busy_a), .cmd_rdy(rdy_a), .cmd(cmd_a), .data(data_a),
      .clr_cmd_rdy(clr_a), .chk_err(chk_a), .timeout_err(to_a));

   uart_pkt_comm #(.DATA_BYTES(3), .BAUD_DIV(BAUD), .CHK_EN(1), .TIMEOUT_CYC(TO_CYC)) u_b (
      .clk(clk), .rst_n(rst_n), .RX(rx_b), .TX(tx_b), .resp(resp_b), .send_resp(send_b),
      .resp_sent(sent_b), .tx_busy(busy_b), .cmd_rdy(rdy_b), .cmd(cmd_b), .data(data_b),
      .clr_cmd_rdy(clr_b), .chk_err(chk_b), .timeout_err(to_b));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sent_a === 1'b1) sent_cnt_a++;
      if (sent_b === 1'b1) sent_cnt_b++;
      if (chk_b === 1'b1) chk_cnt_b++;
      if (to_a === 1'b1) to_cnt_a++;
      if (to_b === 1'b1) to_cnt_b++;
   end

   // Remote-side receiver for the response line of u_a.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge tx_a);
         repeat (BAUD / 2) @(posedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(posedge clk);
            b[i] = tx_a;
         end
         repeat (BAUD) @(posedge clk);
         tx_q.push_back(b);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input bit which, input logic [7:0] b, input int stop_wait);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (which) rx_b = frame[i]; else rx_a = frame[i];
         if (i < 9) repeat (BAUD) @(negedge clk);
      end
      repeat (stop_wait) @(negedge clk);
   endtask

   task automatic send_pkt(input bit which, input logic [7:0] pkt[$]);
      foreach (pkt[j]) send_byte(which, pkt[j], BAUD + 4);
   endtask

   task automatic wait_rdy(input bit which, input string tag);
      int n;
      n = 0;
      while (((which ? rdy_b : rdy_a) !== 1'b1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(which ? rdy_b : rdy_a), 32'd1);
   endtask

   function automatic logic [31:0] pkt_data(input logic [7:0] pkt[$], input int n);
      logic [31:0] d;
      d = 0;
      for (int j = 1; j <= n; j++) d = (d << 8) | 32'(pkt[j]);
      return d;
   endfunction

   function automatic bit pkt_sum_ok(input logic [7:0] pkt[$]);
      int s;
      s = 0;
      foreach (pkt[j]) s += int'(pkt[j]);
      return (s % 256) == 0;
   endfunction

   initial begin
      logic [7:0] pkt[$];
      logic [7:0] exp_cmd_b, r, got;
      logic [31:0] exp_data_b;
      int base, tx_base, to_base, chk_base, s, n;
      bit ok;

      repeat (3) @(negedge clk);
      check("reset_tx_a", 32'(tx_a), 32'd1);
      check("reset_rdy_a", 32'(rdy_a), 32'd0);
      check("reset_cmd_a", 32'(cmd_a), 32'd0);
      check("reset_data_a", 32'(data_a), 32'd0);
      check("reset_busy_a", 32'(busy_a), 32'd0);
      check("reset_tx_b", 32'(tx_b), 32'd1);
      check("reset_rdy_b", 32'(rdy_b), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      pkt = '{8'hA1, 8'hB2, 8'hC3};
      send_pkt(0, pkt);
      wait_rdy(0, "basic_rdy");
      check("basic_cmd", 32'(cmd_a), 32'h0000_00A1);
      check("basic_data", 32'(data_a), 32'h0000_B2C3);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      check("clr_rdy", 32'(rdy_a), 32'd0);

      for (int k = 0; k < 4; k++) begin
         pkt = '{8'($urandom), 8'($urandom), 8'($urandom)};
         send_pkt(0, pkt);
         wait_rdy(0, "rand_a_rdy");
         check("rand_a_cmd", 32'(cmd_a), 32'(pkt[0]));
         check("rand_a_data", 32'(data_a), pkt_data(pkt, 2));
      end

      base = sent_cnt_a;
      tx_base = tx_q.size();
      resp_a = 8'hA5;
      send_a = 1'b1;
      @(negedge clk);
      send_a = 1'b0;
      check("tx_busy_set", 32'(busy_a), 32'd1);
      repeat (50) @(negedge clk);
      resp_a = 8'h5A;
      send_a = 1'b1;
      @(negedge clk);
      send_a = 1'b0;
      n = 0;
      while (sent_cnt_a == base && n < 600) begin
         @(negedge clk);
         n++;
      end
      repeat (40) @(negedge clk);
      check("tx_count", 32'(tx_q.size() - tx_base), 32'd1);
      got = (tx_q.size() > tx_base) ? tx_q[tx_base] : 8'hxx;
      check("tx_byte", 32'(got), 32'h0000_00A5);
      check("resp_sent_once", 32'(sent_cnt_a - base), 32'd1);
      check("tx_busy_clear", 32'(busy_a), 32'd0);

      chk_base = chk_cnt_b;
      pkt = '{8'h23, 8'h08, 8'h97, 8'h11};
      s = 8'h23 + 8'h08 + 8'h97 + 8'h11;
      pkt.push_back(8'(256 - (s % 256)));
      send_pkt(1, pkt);
      wait_rdy(1, "chk_good_rdy");
      check("chk_good_cmd", 32'(cmd_b), 32'h0000_0023);
      check("chk_good_data", 32'(data_b), 32'h0008_9711);
      exp_cmd_b = 8'h23;
      exp_data_b = 32'h0008_9711;
      pkt[4] = pkt[4] ^ 8'h01;
      send_pkt(1, pkt);
      repeat (20) @(negedge clk);
      check("chk_bad_pulse", 32'(chk_cnt_b - chk_base), 32'd1);
      check("chk_bad_rdy", 32'(rdy_b), 32'd0);
      check("chk_bad_cmd", 32'(cmd_b), 32'h0000_0023);
      check("chk_bad_data", 32'(data_b), 32'h0008_9711);

      for (int k = 0; k < 4; k++) begin
         chk_base = chk_cnt_b;
         pkt = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         s = int'(pkt[0]) + int'(pkt[1]) + int'(pkt[2]) + int'(pkt[3]);
         r = 8'(256 - (s % 256));
         if (k % 2 == 1) r = r ^ 8'($urandom_range(1, 255));
         pkt.push_back(r);
         send_pkt(1, pkt);
         repeat (20) @(negedge clk);
         ok = pkt_sum_ok(pkt);
         if (ok) begin
            exp_cmd_b = pkt[0];
            exp_data_b = pkt_data(pkt, 3);
         end
         check("rand_b_rdy", 32'(rdy_b), 32'(ok));
         check("rand_b_chk_err", 32'(chk_cnt_b - chk_base), ok ? 32'd0 : 32'd1);
         check("rand_b_cmd", 32'(cmd_b), 32'(exp_cmd_b));
         check("rand_b_data", 32'(data_b), exp_data_b);
      end

      to_base = to_cnt_a;
      send_byte(0, 8'hA1, BAUD + 4);
      send_byte(0, 8'hB2, BAUD + 4);
      repeat (600) @(negedge clk);
      check("timeout_pulse", 32'(to_cnt_a - to_base), 32'd1);
      check("timeout_rdy", 32'(rdy_a), 32'd0);
      pkt = '{8'h23, 8'h08, 8'h97};
      send_pkt(0, pkt);
      wait_rdy(0, "resync_rdy");
      check("resync_cmd", 32'(cmd_a), 32'h0000_0023);
      check("resync_data", 32'(data_a), 32'h0000_0897);

      pkt = '{8'($urandom), 8'($urandom), 8'($urandom)};
      send_byte(0, pkt[0], BAUD + 4);
      repeat (200) @(negedge clk);
      send_byte(0, pkt[1], BAUD + 4);
      send_byte(0, pkt[2], BAUD + 4);
      wait_rdy(0, "slow_rdy");
      check("slow_data", 32'(data_a), pkt_data(pkt, 2));
      check("slow_no_timeout", 32'(to_cnt_a - to_base), 32'd1);

      pkt = '{8'($urandom), 8'($urandom), 8'($urandom)};
      send_byte(0, pkt[0], BAUD + 4);
      send_byte(0, pkt[1], BAUD + 4);
      clr_a = 1'b1;
      send_byte(0, pkt[2], 0);
      n = 0;
      while (rdy_a !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      clr_a = 1'b0;
      check("commit_beats_clr", 32'(rdy_a), 32'd1);
      repeat (3) @(negedge clk);
      check("commit_clr_hold", 32'(rdy_a), 32'd1);
      check("commit_clr_data", 32'(data_a), pkt_data(pkt, 2));

      base = sent_cnt_a;
      tx_base = tx_q.size();
      r = 8'($urandom);
      resp_a = r;
      send_a = 1'b1;
      @(negedge clk);
      send_a = 1'b0;
      pkt = '{8'($urandom_range(1, 255)), 8'($urandom), 8'($urandom)};
      send_pkt(0, pkt);
      wait_rdy(0, "duplex_rdy");
      check("duplex_cmd", 32'(cmd_a), 32'(pkt[0]));
      check("duplex_data", 32'(data_a), pkt_data(pkt, 2));
      got = (tx_q.size() > tx_base) ? tx_q[tx_base] : 8'hxx;
      check("duplex_tx_byte", 32'(got), 32'(r));
      check("duplex_resp_sent", 32'(sent_cnt_a - base), 32'd1);

      send_byte(0, 8'h3C, BAUD + 4);
      resp_a = 8'hC3;
      send_a = 1'b1;
      @(negedge clk);
      send_a = 1'b0;
      rx_a = 1'b0;
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_rdy", 32'(rdy_a), 32'd0);
      check("rst_cmd", 32'(cmd_a), 32'd0);
      check("rst_data", 32'(data_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      rx_a = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      pkt = '{8'($urandom), 8'($urandom), 8'($urandom)};
      send_pkt(0, pkt);
      wait_rdy(0, "post_rst_rdy");
      check("post_rst_cmd", 32'(cmd_a), 32'(pkt[0]));
      check("post_rst_data", 32'(data_a), pkt_data(pkt, 2));

      check("b_no_timeout", 32'(to_cnt_b), 32'd0);
      check("b_tx_idle", 32'(tx_b), 32'd1);
      check("b_no_resp", 32'(sent_cnt_b), 32'd0);
      check("b_not_busy", 32'(busy_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_pkt_comm.md
Name: uart_pkt_comm

Overview:
Parametrised successor to the quadcopter-side UART command interface. It receives a packet from the remote over a serial line: one command byte, DATA_BYTES data bytes sent MS byte first, and an optional checksum byte. The packet is presented as cmd/data with a sticky cmd_rdy flag. The block also sends single-byte responses back to the remote. Two new features: an inter-byte timeout that resynchronises framing, and checksum validation.

Parameters:
- DATA_BYTES, 2, number of data bytes per packet (1..4); data width is 8*DATA_BYTES.
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud), passed to the UART.
- CHK_EN, 0, 1 = a checksum byte follows the data and is validated.
- TIMEOUT_CYC, 1000000, idle clocks allowed between bytes inside a packet before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- RX  in  1  serial in from the remote
- TX  out  1  serial out to the remote
- resp  in  8  response byte to send
- send_resp  in  1  one-cycle strobe; starts transmission of resp
- resp_sent  out  1  one-cycle pulse when the response stop bit completes
- tx_busy  out  1  high while a response is being transmitted
- cmd_rdy  out  1  sticky: a valid packet is available
- cmd  out  8  command byte of the last valid packet
- data  out  8*DATA_BYTES  data of the last valid packet; the first data byte received occupies the MS byte
- clr_cmd_rdy  in  1  knocks down cmd_rdy
- chk_err  out  1  one-cycle pulse: a packet was rejected on checksum
- timeout_err  out  1  one-cycle pulse: a partial packet was aborted

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - TX=1.
  - cmd_rdy, resp_sent, tx_busy, chk_err and timeout_err = 0.
  - cmd=0, data=0.
  - FSM in IDLE, byte counter 0, timeout counter 0.
- The UART sub-module supplies rx_rdy/rx_data and trmt/tx_done. The rx_rdy strobe is acknowledged (clr_rx_rdy) in the same cycle it is consumed.
- Receive FSM states: IDLE, DATA, CHK.
  - IDLE, byte arrives: load the cmd shadow register, clear cmd_rdy, go to DATA with byte count 0.
  - DATA, each byte: shift into the data shadow register MS first and increment the count. When the count reaches DATA_BYTES-1 and that byte arrives:
    - CHK_EN=0: commit and go to IDLE.
    - CHK_EN=1: go to CHK.
  - CHK, byte arrives: compute the 8-bit wrap-around sum of cmd, all data bytes and the checksum byte.
    - Sum == 8'h00: commit.
    - Otherwise: pulse chk_err for one cycle; cmd, data and cmd_rdy are unchanged.
    - Either way, return to IDLE.
- Commit: copy the shadow registers to cmd/data and set cmd_rdy. These take effect the cycle after the final rx_rdy.
- cmd/data change only on a commit. They are stable for the whole time cmd_rdy is high.
- cmd_rdy clearing:
  - Cleared by clr_cmd_rdy or by the arrival of a new first byte.
  - If a commit and clr_cmd_rdy occur in the same cycle, the commit wins and cmd_rdy=1.
- Timeout:
  - The counter runs only in DATA/CHK and resets on every received byte.
  - When it reaches TIMEOUT_CYC-1: pulse timeout_err, go to IDLE, discard the shadow registers. Outputs are untouched.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Transmit path:
  - send_resp while tx_busy=0: latch resp, start the UART, set tx_busy.
  - tx_done: clear tx_busy and pulse resp_sent.
  - send_resp while tx_busy=1 is ignored; the in-flight byte is not corrupted.
- Transmit and receive are fully independent. Simultaneous activity in both directions is legal.
- Reset mid-packet or mid-transmit returns to the reset state immediately and TX goes to 1. No partial commit.

Decomposition:
- Shared package uart_pkt_pkg contains:
  - rx_state_t enum {IDLE, DATA, CHK};
  - the function chk_sum(cmd, data) that returns the 8-bit checksum.
- Sub-module: the existing UART (transceiver), instantiated once with BAUD_DIV.
- The packet FSM, shadow registers and timeout counter live in uart_pkt_comm itself.

Test Plan:
- Defaults. Remote sends A1,B2,C3 → on the cmd_rdy rise, cmd=A1 and data=B2C3. clr_cmd_rdy → cmd_rdy=0 next cycle.
- send_resp with resp=A5 → the remote receives A5. resp_sent pulses once. A second send_resp mid-transfer is ignored and the remote still receives only A5.
- DATA_BYTES=3, CHK_EN=1:
  - Send 23,08,97,11,chk → cmd=23, data=089711.
  - Same packet with a corrupted chk → chk_err pulses, cmd_rdy stays 0 and cmd/data keep their old values.
- TIMEOUT_CYC=5000. Send A1,B2 then stall 6000 clks → timeout_err pulses. Then send 23,08,97 → cmd=23, data=0897, with no framing slip.
- Commit cycle with clr_cmd_rdy asserted → cmd_rdy=1. Command receive during an active response transmit → both complete correctly.
- rst_n low mid-packet and mid-transmit → TX=1, cmd_rdy=0, cmd=0. The next full packet is received correctly.
